// File: rtl/uart_word_receiver.sv
// ============================================================================
// Module      : uart_word_receiver
// Description : UART receiver (8 data bits, LSB first, 1 stop bit) that packs
//               four consecutive bytes little-endian into a 32-bit word and
//               presents it through a valid/ready holding register.
//               Optional build macro: UART_RX_PARITY_EN adds an even-parity
//               bit after data bit 7.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_word_receiver #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        uart_rx,
  input  logic        word_ready,
  output logic        word_valid,
  output logic [31:0] word,
  output logic        frame_err,
  output logic        overrun
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [31:0]      NOP_WORD = 32'h0000_0013;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3
`ifdef UART_RX_PARITY_EN
    ,
    S_PARITY = 3'd4
`endif
  } state_t;

  state_t           state;
  logic             rx_meta;
  logic             rx_sync;
  logic             rx_prev;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [1:0]       byte_idx;
  logic [7:0]       shift;
  logic [23:0]      stage;
  logic             bad_frame;
`ifdef UART_RX_PARITY_EN
  logic             parity_err;
`endif

  // A stop bit sampled low (or a parity mismatch) invalidates the byte.
`ifdef UART_RX_PARITY_EN
  assign bad_frame = !rx_sync || parity_err;
`else
  assign bad_frame = !rx_sync;
`endif

  // Two-flop synchronizer plus one history flop for falling-edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // Receive FSM, byte packing and word holding register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      byte_idx   <= '0;
      shift      <= '0;
      stage      <= '0;
      word       <= NOP_WORD;
      word_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      // A consumed word drops valid unless a new word reloads it below.
      if (word_valid && word_ready) begin
        word_valid <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
          if (rx_prev && !rx_sync) begin
            state <= S_START;
          end
        end

        S_START: begin
          if (cnt == HALF_M1) begin
            cnt   <= '0;
            // Line back high at mid start bit: a glitch, drop silently.
            state <= rx_sync ? S_IDLE : S_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_DATA: begin
          if (cnt == FULL_M1) begin
            cnt     <= '0;
            shift   <= {rx_sync, shift[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= S_PARITY;
`else
              state <= S_STOP;
`endif
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (cnt == FULL_M1) begin
            cnt        <= '0;
            parity_err <= ^{shift, rx_sync};
            state      <= S_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif

        S_STOP: begin
          if (cnt == FULL_M1) begin
            cnt   <= '0;
            state <= S_IDLE;
            if (bad_frame) begin
              frame_err <= 1'b1;
              byte_idx  <= '0;
              stage     <= '0;
            end else begin
              byte_idx <= byte_idx + 1'b1;
              case (byte_idx)
                2'd0: stage[7:0]   <= shift;
                2'd1: stage[15:8]  <= shift;
                2'd2: stage[23:16] <= shift;
                default: begin
                  if (!word_valid || word_ready) begin
                    word       <= {shift, stage};
                    word_valid <= 1'b1;
                  end else begin
                    overrun <= 1'b1;
                  end
                end
              endcase
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
